// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and op in, registered result and flags out.
// The master drives the request side and the slave (the ALU) drives the response side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [3:0]       fi;
    logic [WIDTH-1:0] d;
    logic [3:0]       fo;
    logic             out_valid;

    modport master (
        output in_valid, a, b, op, fi,
        input  in_ready, d, fo, out_valid
    );

    modport slave (
        input  in_valid, a, b, op, fi,
        output in_ready, d, fo, out_valid
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide sharing one WIDTH-bit adder.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic    clk,
    input  logic    rst,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_mop;
    logic             r_dz;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic [3:0]       r_fo;
    logic             r_outValid;

    logic [SHW-1:0]   w_s;
    logic [WIDTH-1:0] w_addX;
    logic [WIDTH-1:0] w_addY;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic             w_divOk;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_qNext;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_finD;
    logic             w_finC;
    logic             w_finV;
    logic             w_isMulti;
    logic             w_unusedFi;

    assign w_s        = bus.b[SHW-1:0];
    assign w_isMulti  = bus.op[3] & bus.op[2];
    assign w_unusedFi = ^bus.fi[3:1];
    assign w_trial    = {r_acc, r_q[WIDTH-1]};

    // The one adder serves add/sub when idle, and one multiply/divide step when busy.
    always_comb begin
        w_addX = bus.a;
        w_addY = bus.op[1] ? ~bus.b : bus.b;
        w_cin  = bus.op[0] ? bus.fi[0] : bus.op[1];
        if (r_state == BUSY) begin
            if (r_mop[1]) begin
                w_addX = w_trial[WIDTH-1:0];
                w_addY = ~r_b;
                w_cin  = 1'b1;
            end else begin
                w_addX = r_acc;
                w_addY = r_b;
                w_cin  = 1'b0;
            end
        end
    end

    assign w_sum = {1'b0, w_addX} + {1'b0, w_addY} + {{WIDTH{1'b0}}, w_cin};

    // A trial remainder with its top bit set always exceeds the divisor, even if the
    // WIDTH-bit subtraction wraps.
    always_comb begin
        w_divOk   = w_trial[WIDTH] | w_sum[WIDTH];
        w_mulSum  = r_q[0] ? w_sum : {1'b0, r_acc};
        w_accNext = w_mulSum[WIDTH:1];
        w_qNext   = {w_mulSum[0], r_q[WIDTH-1:1]};
        if (r_mop[1]) begin
            w_accNext = w_divOk ? w_sum[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_qNext   = {r_q[WIDTH-2:0], w_divOk};
        end
    end

    always_comb begin
        w_finD = r_mop[0] ? w_accNext : w_qNext;
        w_finC = (r_mop == 2'b00) & (|w_accNext);
        w_finV = r_mop[1] & r_dz;
    end

    assign w_shl = {1'b0, bus.a} << w_s;
    assign w_shr = {bus.a, 1'b0} >> w_s;
    assign w_asr = $signed({bus.a, 1'b0}) >>> w_s;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.a[WIDTH-1] == w_addY[WIDTH-1]) &
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd4:  w_res = bus.a & bus.b;
            4'd5:  w_res = bus.a | bus.b;
            4'd6:  w_res = bus.a ^ bus.b;
            4'd7:  w_res = ~bus.a;
            4'd8: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            4'd9: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            4'd10: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            4'd11: w_res = bus.b;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mop      <= '0;
            r_dz       <= 1'b0;
            r_acc      <= '0;
            r_q        <= '0;
            r_b        <= '0;
            r_d        <= '0;
            r_fo       <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!w_isMulti) begin
                            r_d        <= w_res;
                            r_fo       <= {w_v, w_res[WIDTH-1], (w_res == '0), w_c};
                            r_outValid <= 1'b1;
                        end else begin
                            r_acc   <= '0;
                            r_q     <= bus.a;
                            r_b     <= bus.b;
                            r_mop   <= bus.op[1:0];
                            r_dz    <= (bus.b == '0);
                            r_cnt   <= CW'(WIDTH);
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_acc <= w_accNext;
                    r_q   <= w_qNext;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_d        <= w_finD;
                        r_fo       <= {w_finV, w_finD[WIDTH-1], (w_finD == '0), w_finC};
                        r_outValid <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.d         = r_d;
    assign bus.fo        = r_fo;
    assign bus.out_valid = r_outValid;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: the next generation of the CPU's 8-bit ALU. It is generalised to `WIDTH` bits and adds a valid/ready input handshake, registered results, and iterative multi-cycle multiply and divide. It sits between the register-file read stage and writeback, and stalls issue through `in_ready` while a multi-cycle operation runs.

## Interface
- `WIDTH`, 8: operand/result width. Power of two, ≥4.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block can accept. High iff state is IDLE.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B. `b[SHW-1:0]` is the shift amount for shift ops.
- `op` in 4: operation select.
- `fi` in 4: flags in, `{V,N,Z,C}`. Only `fi[0]` (C) is used.
- `d` out `WIDTH`: registered result. Held until the next result.
- `fo` out 4: registered flags `{V,N,Z,C}`. Held with `d`.
- `out_valid` out 1: one-cycle pulse when a new `d`/`fo` is written.

## Operation
- Accept occurs on an edge where `in_valid && in_ready`. `a`, `b`, `op` and `fi` are captured at accept; input changes after accept are ignored.
- Op encoding: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, 10 ASR, 11 PASSB, 12 MUL, 13 MULH, 14 DIV, 15 MOD.
- ADD: `a+b`. ADC: `a+b+fi[0]`.
  - C = carry out of bit `WIDTH-1`.
  - V = signed overflow.
- SUB: `a+~b+1`. SBC: `a+~b+fi[0]`.
  - C = 1 means no borrow, so SUB sets C=1 iff `a>=b` unsigned.
  - V = signed overflow.
- AND/OR/XOR/NOT(`~a`)/PASSB(`b`): C=0, V=0.
- SHL/SHR/ASR by `s=b[SHW-1:0]`:
  - C = last bit shifted out; C=0 when `s==0`.
  - V=0.
  - ASR replicates `a[WIDTH-1]`.
- MUL/MULH: unsigned `2*WIDTH` product.
  - MUL returns the low half; C=1 iff the high half is nonzero.
  - MULH returns the high half; C=0.
  - V=0.
- DIV/MOD: unsigned restoring division, C=0.
  - DIV returns the quotient, MOD the remainder.
  - Divide by zero: DIV gives all-ones with V=1; MOD gives `a` with V=1. Divide by zero still takes full latency.
- Z = (`d==0`) and N = `d[WIDTH-1]` for every op.
- FSM:
  - IDLE: accepting a single-cycle op (0–11) computes and registers `d`/`fo` and pulses `out_valid`; the state stays IDLE. Accepting an op 12–15 loads the operands and the iteration counter with `WIDTH`, then goes to BUSY.
  - BUSY: one shift-add or shift-subtract iteration per cycle; the counter decrements. On the edge where the counter reaches 1→0, the final result is written, `out_valid` pulses, and the state returns to IDLE.
- No multiply or divide combinational array. The datapath is a single `WIDTH`-bit adder/subtractor plus shift registers.

## Timing
- Reset (`rst`=0, asynchronous) forces, immediately:
  - `d`=0, `fo`=0, `out_valid`=0.
  - state IDLE, counter 0, so `in_ready`=1.
- Reset mid-BUSY aborts the operation; no `out_valid` is produced for it.
- Single-cycle ops, accepted at edge N:
  - `d`/`fo` are valid and `out_valid`=1 after edge N.
  - Back-to-back accepts every cycle give a continuous `out_valid`.
- Multi-cycle ops, accepted at edge N:
  - `in_ready`=0 after edge N.
  - The result and the `out_valid` pulse arrive after edge N+`WIDTH`; `in_ready`=1 again at the same point.
  - The earliest next accept is edge N+`WIDTH`+1.
- During BUSY, `d`/`fo` hold the previous result and `out_valid`=0.
- `in_valid` while `in_ready`=0 has no effect. The requester must hold the request.

## Test plan
- Reset, then at `WIDTH`=8 issue ADD a=1, b=100 → `d`=101, `fo`=0, `out_valid` high for exactly one cycle one edge after accept; `in_ready` stays 1.
- Issue ADC 0xFF+0x01 with fi=1 → `d`=0x01, C=1. Then SUB 0x80−0x01 → `d`=0x7F, C=1, V=1. Then SUB 0x05−0x05 → `d`=0, Z=1, C=1. Issue these back-to-back → three consecutive `out_valid` cycles.
- Issue SHL 0x81 by 1 → `d`=0x02, C=1. ASR 0x80 by 2 → `d`=0xE0, N=1, C=0. SHR 0x01 by 0 → `d`=0x01, C=0.
- Issue MUL 43×7 → `d`=0x2D, C=1, with `out_valid` 8 edges after accept and `in_ready` low for 8 cycles. Then MULH 43×7 → `d`=0x01. Toggle `a`/`b` during BUSY → result unchanged.
- Issue DIV 100/7 → `d`=14. MOD 100/7 → `d`=2. DIV 9/0 → `d`=0xFF, V=1, N=1. MOD 9/0 → `d`=9, V=1.
- Start DIV 100/7, assert `rst` 3 cycles into BUSY → `d`/`fo`/`out_valid` go to 0 immediately and no `out_valid` pulse follows. Release `rst`, then issue ADD 43+1 → `d`=44.
